mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencer between the execute stage and the `mdu` multiply/divide unit of the RV32IMZ core. It accepts one M-extension op at a time, launches `mdu`, and stalls the issuing stage while `mdu` runs. It selects the architectural result by funct3 and delivers it to writeback through a valid/ready handshake. A one-entry divide-result cache lets a REM that follows a DIV on the same operands (or the reverse pairing) complete without re-running `mdu`.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  M-op offered by execute
- `ex_ready`  out  1  = (state==IDLE) && !flush
- `ex_funct3`  in  3  M-op selector (MUL..REMU)
- `ex_rs1`, `ex_rs2`  in  32 each  operands
- `ex_rd`  in  5  destination register
- `flush`  in  1  pipeline kill; discards the in-flight op
- `stall`  out  1  = (state!=IDLE)
- `mdu_start`  out  1  launch pulse to `mdu`
- `mdu_a`, `mdu_b`  out  32 each  operand registers
- `mdu_funct3`  out  3  op register
- `mdu_busy`, `mdu_done`  in  1 each  `mdu` status; `done` is a 1-cycle pulse
- `mdu_product`  in  64  full product
- `mdu_quotient`, `mdu_remainder`  in  32 each
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  writeback accepts
- `wb_rd`  out  5
- `wb_data`  out  32

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- Accept when `ex_valid && ex_ready`: latch funct3/rs1/rs2/rd into `mdu_funct3`/`mdu_a`/`mdu_b`/`wb_rd`.
  - Cache hit: go to RESP with the cached value loaded into `wb_data`.
  - Cache miss: go to ISSUE.
- ISSUE: `mdu_start = !mdu_busy`, combinational.
  - Start asserted: go to WAIT.
  - Start not asserted: hold in ISSUE.
- WAIT: on `mdu_done`, capture and select, then go to RESP.
  - MUL: `product[31:0]`.
  - MULH/MULHSU/MULHU: `product[63:32]`.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- RESP: `wb_valid=1` and `wb_data`/`wb_rd` stay stable until `wb_ready`, then go to IDLE.
- Divide cache fields: valid, signed bit (funct3 ∈ {DIV,REM}), a, b, quotient, remainder.
  - Filled on every `mdu_done` for funct3 ≥ 4, including DRAIN completions.
  - Hit condition: funct3 ≥ 4, valid, signedness match, a and b both equal.
  - Multiplies never hit and never touch the cache.
  - Cleared only by reset. `flush` does not clear it, because the cached results are pure functions of the operands.
- Flush behaviour:
  - In IDLE: blocks accept.
  - In ISSUE: if `mdu_start` fires that cycle, go to DRAIN, otherwise go to IDLE.
  - In WAIT: go to DRAIN.
  - In RESP: drop `wb_valid` next cycle and go to IDLE.
  - DRAIN: wait for `mdu_done` (fill cache if divide), never raise `wb_valid`, then go to IDLE.
- `flush` and `wb_ready` in the same RESP cycle: the handshake completes. Writeback decides whether to keep the result.

## Timing
- Reset values: state IDLE, `mdu_a`/`mdu_b`/`wb_data`=0, `mdu_funct3`/`wb_rd`=0, `wb_valid`=0, `stall`=0, `mdu_start`=0, cache valid=0. `ex_ready` = `!flush`.
- Miss latency, counted from the accept edge:
  - `mdu_start` is high in cycle +1 when `mdu_busy`=0.
  - `wb_valid` rises one cycle after the edge that samples `mdu_done`.
- Hit latency: `wb_valid` is high in cycle +1. No `mdu_start` is issued.
- Throughput: one op in flight. The next accept happens no earlier than the cycle after the `wb_valid && wb_ready` edge.
- `mdu_start` never asserts outside ISSUE. It is high for exactly one cycle per issue.

## Structure
- Shared package `rv32_m_pkg` holds:
  - the `FUNCT3_MUL`…`FUNCT3_REMU` constants, shared with `mdu`;
  - the `mdu_ctrl_state_t` enum;
  - the `is_div(funct3)` and `is_signed_div(funct3)` helper functions.
- Sub-module `mdu_div_cache` holds the one-entry cache: fill port, lookup port, and a combinational hit/data output.
- The FSM and result mux stay in `mdu_ctrl`.

## Test plan
- DIV 20/4 (miss), then REM 20,4 → first: `wb_data`=5; second: hit, `wb_data`=0, no `mdu_start`, `wb_valid` at cycle +1.
- DIV −21/4, then DIVU 0xFFFFFFEB/4 → −5 (0xFFFFFFFB); then miss (signedness differs), 0x3FFFFFFA.
- MUL 0xFFFFFFFE×3 → 0xFFFFFFFA. MULH same operands → 0xFFFFFFFF. MULHU → 0x00000002.
- Flush while in WAIT on DIV 100/7 → no `wb_valid`, `ex_ready` low until `mdu_done` plus one cycle. Then REM 100,7 → hit, 2.
- `wb_ready` held low 5 cycles in RESP → `wb_valid`/`wb_data`/`wb_rd` stable all 5 cycles, then one handshake and return to IDLE.
- `rst_n` asserted in WAIT → all outputs at reset values immediately. The cache is cleared, so a following REM 20,4 misses and issues `mdu_start`.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rv32_m_pkg: M-extension funct3 codes, sequencer states and divide classification helpers
package rv32_m_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_RESP
  } mdu_ctrl_state_t;

  // Every divide/remainder op has funct3[2] set.
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // DIV and REM are the signed divides; the U variants have funct3[0] set.
  function automatic logic is_signed_div(input logic [2:0] f);
    return f[2] & ~f[0];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: execute, mdu and writeback signals of the M-op sequencer
interface mdu_ctrl_if #(parameter int XLEN = 32);

  logic              ex_valid;
  logic              ex_ready;
  logic [2:0]        ex_funct3;
  logic [XLEN-1:0]   ex_rs1;
  logic [XLEN-1:0]   ex_rs2;
  logic [4:0]        ex_rd;
  logic              flush;
  logic              stall;
  logic              mdu_start;
  logic [XLEN-1:0]   mdu_a;
  logic [XLEN-1:0]   mdu_b;
  logic [2:0]        mdu_funct3;
  logic              mdu_busy;
  logic              mdu_done;
  logic [2*XLEN-1:0] mdu_product;
  logic [XLEN-1:0]   mdu_quotient;
  logic [XLEN-1:0]   mdu_remainder;
  logic              wb_valid;
  logic              wb_ready;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  // Environment side: execute, mdu and writeback.
  modport master (
    output ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
           mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder, wb_ready,
    input  ex_ready, stall, mdu_start, mdu_a, mdu_b, mdu_funct3, wb_valid, wb_rd, wb_data
  );

  // Sequencer side.
  modport slave (
    input  ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
           mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder, wb_ready,
    output ex_ready, stall, mdu_start, mdu_a, mdu_b, mdu_funct3, wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/mdu_div_cache.sv
// mdu_div_cache: one-entry cache of the last divide's quotient and remainder
module mdu_div_cache
  import rv32_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fill_i,
  input  logic            fill_signed_i,
  input  logic [XLEN-1:0] fill_a_i,
  input  logic [XLEN-1:0] fill_b_i,
  input  logic [XLEN-1:0] fill_q_i,
  input  logic [XLEN-1:0] fill_r_i,
  input  logic [2:0]      lk_funct3_i,
  input  logic [XLEN-1:0] lk_a_i,
  input  logic [XLEN-1:0] lk_b_i,
  output logic            hit_o,
  output logic [XLEN-1:0] data_o
);

  logic            valid_q;
  logic            sgn_q;
  logic [XLEN-1:0] a_q, b_q, quo_q, rem_q;

  // Capture operands and both results of every completed divide; only reset invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      sgn_q   <= fill_signed_i;
      a_q     <= fill_a_i;
      b_q     <= fill_b_i;
      quo_q   <= fill_q_i;
      rem_q   <= fill_r_i;
    end
  end

  assign hit_o  = is_div(lk_funct3_i) && valid_q && (sgn_q == is_signed_div(lk_funct3_i)) &&
                  (a_q == lk_a_i) && (b_q == lk_b_i);
  assign data_o = lk_funct3_i[1] ? rem_q : quo_q;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences one M-op at a time through mdu and hands the result to writeback
module mdu_ctrl
  import rv32_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mdu_ctrl_if.slave    bus
);

  mdu_ctrl_state_t state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            accept, start, hit, fill;
  logic [XLEN-1:0] hit_data, result;

  assign bus.ex_ready   = (state_q == ST_IDLE) && !bus.flush;
  assign bus.stall      = (state_q != ST_IDLE);
  assign bus.wb_valid   = (state_q == ST_RESP);
  assign bus.mdu_start  = start;
  assign bus.mdu_a      = a_q;
  assign bus.mdu_b      = b_q;
  assign bus.mdu_funct3 = f3_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_q;

  assign accept = bus.ex_valid && bus.ex_ready;
  assign start  = (state_q == ST_ISSUE) && !bus.mdu_busy;
  assign fill   = ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && bus.mdu_done && is_div(f3_q);
  assign result = (f3_q == FUNCT3_MUL) ? bus.mdu_product[XLEN-1:0] :
                  !f3_q[2]             ? bus.mdu_product[2*XLEN-1:XLEN] :
                  f3_q[1]              ? bus.mdu_remainder : bus.mdu_quotient;

  mdu_div_cache #(.XLEN(XLEN)) u_cache (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_i       (fill),
    .fill_signed_i(is_signed_div(f3_q)),
    .fill_a_i     (a_q),
    .fill_b_i     (b_q),
    .fill_q_i     (bus.mdu_quotient),
    .fill_r_i     (bus.mdu_remainder),
    .lk_funct3_i  (bus.ex_funct3),
    .lk_a_i       (bus.ex_rs1),
    .lk_b_i       (bus.ex_rs2),
    .hit_o        (hit),
    .data_o       (hit_data)
  );

  // State and op/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // Next state: accept/lookup, launch, collect, and flush handling; a done that coincides
  // with a flush in WAIT retires straight to IDLE since DRAIN would wait for a second done.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        a_d     = bus.ex_rs1;
        b_d     = bus.ex_rs2;
        f3_d    = bus.ex_funct3;
        rd_d    = bus.ex_rd;
        data_d  = hit ? hit_data : data_q;
        state_d = hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: state_d = bus.flush ? (start ? ST_DRAIN : ST_IDLE) : (start ? ST_WAIT : ST_ISSUE);
      ST_WAIT: if (bus.mdu_done) begin
        data_d  = result;
        state_d = bus.flush ? ST_IDLE : ST_RESP;
      end else if (bus.flush) begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = bus.mdu_done ? ST_IDLE : ST_DRAIN;
      ST_RESP:  state_d = (bus.wb_ready || bus.flush) ? ST_IDLE : ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector table plus flush, backpressure and reset sequences for mdu_ctrl
module tb_mdu_ctrl;
  import rv32_m_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          hit;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   m_cnt;
  vec_t v[12];

  mdu_ctrl_if #(.XLEN(32)) bus ();

  mdu_ctrl #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mdu_start) start_cnt <= start_cnt + 1;

  function automatic logic [63:0] model_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (f != FUNCT3_MULHU && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    eb = ((f == FUNCT3_MUL || f == FUNCT3_MULH) && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] model_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 0) return {32'hFFFFFFFF, a};
    if (!f[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {a, 32'h0};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr};
    end
    return {a / b, a % b};
  endfunction

  // Behavioural mdu: busy for three cycles after a start, then a one-cycle done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mdu_busy      <= 1'b0;
      bus.mdu_done      <= 1'b0;
      bus.mdu_product   <= '0;
      bus.mdu_quotient  <= '0;
      bus.mdu_remainder <= '0;
      m_cnt             <= 0;
    end else begin
      bus.mdu_done <= 1'b0;
      if (bus.mdu_busy) begin
        if (m_cnt == 1) begin
          bus.mdu_busy <= 1'b0;
          bus.mdu_done <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end else if (bus.mdu_start) begin
        bus.mdu_busy <= 1'b1;
        m_cnt        <= 3;
        bus.mdu_product <= model_mul(bus.mdu_funct3, bus.mdu_a, bus.mdu_b);
        {bus.mdu_quotient, bus.mdu_remainder} <= model_div(bus.mdu_funct3, bus.mdu_a, bus.mdu_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.ex_valid  = 1'b1;
    bus.ex_funct3 = f;
    bus.ex_rs1    = a;
    bus.ex_rs2    = b;
    bus.ex_rd     = rd;
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit hit, input int hold);
    int s0, cyc;
    bit got, seen_done;
    @(negedge clk);
    chk({nm, " ex_ready"}, bus.ex_ready, 1);
    s0 = start_cnt;
    drive_op(f, a, b, rd);
    @(negedge clk);
    chk({nm, " start@+1"}, bus.mdu_start, !hit);
    chk({nm, " wb_valid@+1"}, bus.wb_valid, hit);
    got = bus.wb_valid;
    cyc = 1;
    while (!got && cyc < 60) begin
      seen_done = bus.mdu_done;
      @(negedge clk);
      cyc++;
      if (seen_done) chk({nm, " done->valid"}, bus.wb_valid, 1);
      got = bus.wb_valid;
    end
    if (!got) chk({nm, " timeout"}, 0, 1);
    chk({nm, " wb_data"}, bus.wb_data, exp);
    chk({nm, " wb_rd"}, bus.wb_rd, rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold valid"}, bus.wb_valid, 1);
      chk({nm, " hold data"}, bus.wb_data, exp);
      chk({nm, " hold rd"}, bus.wb_rd, rd);
    end
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1 bus.wb_ready = 1'b0;
    @(negedge clk);
    chk({nm, " valid dropped"}, bus.wb_valid, 0);
    chk({nm, " back idle"}, bus.stall, 0);
    chk({nm, " start count"}, start_cnt - s0, hit ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit ok, pend, vflag, rbad;
    v[0]  = '{FUNCT3_DIV,    32'd20,        32'd4, 5'd1,  32'd5,        1'b0};
    v[1]  = '{FUNCT3_REM,    32'd20,        32'd4, 5'd2,  32'd0,        1'b1};
    v[2]  = '{FUNCT3_DIV,    32'hFFFFFFEB,  32'd4, 5'd3,  32'hFFFFFFFB, 1'b0};
    v[3]  = '{FUNCT3_DIVU,   32'hFFFFFFEB,  32'd4, 5'd4,  32'h3FFFFFFA, 1'b0};
    v[4]  = '{FUNCT3_REMU,   32'hFFFFFFEB,  32'd4, 5'd5,  32'd3,        1'b1};
    v[5]  = '{FUNCT3_MUL,    32'hFFFFFFFE,  32'd3, 5'd6,  32'hFFFFFFFA, 1'b0};
    v[6]  = '{FUNCT3_MULH,   32'hFFFFFFFE,  32'd3, 5'd7,  32'hFFFFFFFF, 1'b0};
    v[7]  = '{FUNCT3_MULHSU, 32'hFFFFFFFE,  32'd3, 5'd8,  32'hFFFFFFFF, 1'b0};
    v[8]  = '{FUNCT3_MULHU,  32'hFFFFFFFE,  32'd3, 5'd9,  32'd2,        1'b0};
    v[9]  = '{FUNCT3_REMU,   32'hFFFFFFEB,  32'd4, 5'd10, 32'd3,        1'b1};
    v[10] = '{FUNCT3_REM,    32'hFFFFFFEB,  32'd4, 5'd11, 32'hFFFFFFFF, 1'b0};
    v[11] = '{FUNCT3_DIV,    32'hFFFFFFEB,  32'd4, 5'd31, 32'hFFFFFFFB, 1'b1};

    rst_n = 1'b0;
    bus.flush = 1'b1;
    bus.ex_valid = 1'b0;
    bus.ex_funct3 = '0;
    bus.ex_rs1 = '0;
    bus.ex_rs2 = '0;
    bus.ex_rd = '0;
    bus.wb_ready = 1'b0;
    #1;
    chk("reset ex_ready under flush", bus.ex_ready, 0);
    bus.flush = 1'b0;
    #1;
    chk("reset ex_ready", bus.ex_ready, 1);
    chk("reset stall", bus.stall, 0);
    chk("reset wb_valid", bus.wb_valid, 0);
    chk("reset mdu_start", bus.mdu_start, 0);
    chk("reset mdu_a", bus.mdu_a, 0);
    chk("reset mdu_b", bus.mdu_b, 0);
    chk("reset wb_data", bus.wb_data, 0);
    chk("reset wb_rd", bus.wb_rd, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), v[i].f3, v[i].a, v[i].b, v[i].rd, v[i].exp, v[i].hit, 0);

    // Flush while waiting on DIV 100/7; the result must still land in the cache.
    @(negedge clk);
    drive_op(FUNCT3_DIV, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    chk("flush start@+1", bus.mdu_start, 1);
    @(negedge clk);
    chk("flush stalled in wait", bus.stall, 1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    ok = 0; pend = 0; vflag = 0; rbad = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.wb_valid) vflag = 1;
      if (pend) begin
        chk("flush ready after done", bus.ex_ready, 1);
        ok = 1;
      end else begin
        if (bus.ex_ready) rbad = 1;
        pend = bus.mdu_done;
      end
    end
    if (!ok) chk("flush drain timeout", 0, 1);
    chk("flush no wb_valid", vflag, 0);
    chk("flush ready early", rbad, 0);
    do_op("rem after flush", FUNCT3_REM, 32'd100, 32'd7, 5'd4, 32'd2, 1'b1, 0);

    do_op("backpressure", FUNCT3_DIVU, 32'd200, 32'd3, 5'd9, 32'h42, 1'b0, 5);

    // Fill the cache, then reset mid-multiply and confirm the cache was cleared.
    do_op("prefill", FUNCT3_DIV, 32'd20, 32'd4, 5'd1, 32'd5, 1'b0, 0);
    @(negedge clk);
    drive_op(FUNCT3_MUL, 32'd7, 32'd6, 5'd12);
    @(negedge clk);
    chk("rst start@+1", bus.mdu_start, 1);
    @(negedge clk);
    chk("rst in wait", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst stall", bus.stall, 0);
    chk("rst wb_valid", bus.wb_valid, 0);
    chk("rst mdu_start", bus.mdu_start, 0);
    chk("rst mdu_a", bus.mdu_a, 0);
    chk("rst mdu_b", bus.mdu_b, 0);
    chk("rst mdu_funct3", bus.mdu_funct3, 0);
    chk("rst wb_rd", bus.wb_rd, 0);
    chk("rst wb_data", bus.wb_data, 0);
    chk("rst ex_ready", bus.ex_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("rem after reset", FUNCT3_REM, 32'd20, 32'd4, 5'd2, 32'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
